// File: rtl/sdram_arbiter_pkg.sv
// Shared definitions for the three-port SDRAM burst arbiter: state encoding,
// port count and default parameter values.
package sdram_arbiter_pkg;

  localparam int          NUM_REQ        = 3;
  localparam logic [7:0]  BURST_LEN_DEF  = 8'd32;
  localparam int          READ_SKIP_DEF  = 2;
  localparam logic [15:0] TIMEOUT_DEF    = 16'd4095;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_REQ   = 3'd2,
    ST_BURST = 3'd3,
    ST_DONE  = 3'd4
  } sdram_state_e;

  function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    case (idx)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin selector: the search starts at ptr+1 (mod 3) and
// wraps, so the last winner is always considered last.
module rr_arbiter3
  import sdram_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [1:0]         grant,
  output logic               any
);

  always_comb begin
    any   = |req;
    grant = 2'd0;
    case (ptr)
      2'd0:    grant = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    grant = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: grant = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter feeding three requesters into one SDRAM burst controller.
// Handshake: a requester holds req_valid (with rw/addr stable) until it sees a
// one-cycle req_ready pulse; the request is accepted on that cycle and req_valid
// may drop on the next. Write words advance one cycle after each wr_take beat.
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter logic [7:0]  BURST_LEN = BURST_LEN_DEF,
  parameter int          READ_SKIP = READ_SKIP_DEF,
  parameter logic [15:0] TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_rw,
  input  logic [32*NUM_REQ-1:0]    req_addr,
  input  logic [16*NUM_REQ-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       wr_take,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [15:0]              rsp_rdata,
  output logic                     busy,
  output logic                     timeout_err,
  output logic                     sd_ce,
  output logic                     sd_rw_req,
  output logic                     sd_rw,
  output logic [31:0]              sd_address,
  output logic [7:0]               sd_burst_len,
  output logic [15:0]              sd_write_data,
  input  logic [15:0]              sd_read_data,
  input  logic                     sd_data_bursting,
  output sdram_state_e             dbg_state
);

  localparam logic [7:0] SKIP_BEATS = 8'(READ_SKIP);

  // Assertion is immediate; release waits two clocks so every flop leaves
  // reset on the same edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  sdram_state_e       state;
  logic [1:0]         ptr;
  logic [1:0]         grant_q;
  logic [1:0]         arb_grant;
  logic               arb_any;
  logic [7:0]         beat_cnt;
  logic [15:0]        to_cnt;
  logic [31:0]        addr_sel;
  logic               rw_sel;
  logic [15:0]        wdata_sel;
  logic               burst_beat;
  logic [7:0]         beat_idx;
  logic [NUM_REQ-1:0] grant_oh;

  rr_arbiter3 u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (arb_grant),
    .any   (arb_any)
  );

  always_comb begin
    addr_sel = req_addr[31:0];
    rw_sel   = req_rw[0];
    case (arb_grant)
      2'd1: begin
        addr_sel = req_addr[63:32];
        rw_sel   = req_rw[1];
      end
      2'd2: begin
        addr_sel = req_addr[95:64];
        rw_sel   = req_rw[2];
      end
      default: ;
    endcase
  end

  always_comb begin
    wdata_sel = req_wdata[15:0];
    case (grant_q)
      2'd1:    wdata_sel = req_wdata[31:16];
      2'd2:    wdata_sel = req_wdata[47:32];
      default: ;
    endcase
  end

  // The controller may start bursting while the strobe is still up, so the
  // first beat is seen in REQ and counts as beat 0.
  assign burst_beat    = sd_data_bursting && (state == ST_REQ || state == ST_BURST);
  assign beat_idx      = (state == ST_BURST) ? beat_cnt : 8'd0;
  assign grant_oh      = idx_onehot(grant_q);
  assign req_ready     = (state == ST_ARB && arb_any) ? idx_onehot(arb_grant) : '0;
  assign wr_take       = (burst_beat && sd_rw) ? grant_oh : '0;
  assign sd_write_data = ((state == ST_REQ || state == ST_BURST) && sd_rw) ? wdata_sel : 16'h0000;
  assign sd_burst_len  = BURST_LEN;
  assign dbg_state     = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ptr         <= 2'd2;
      grant_q     <= 2'd0;
      beat_cnt    <= 8'd0;
      to_cnt      <= 16'd0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      sd_ce       <= 1'b0;
      sd_rw_req   <= 1'b0;
      sd_rw       <= 1'b0;
      sd_address  <= 32'h0;
      rsp_valid   <= '0;
      rsp_rdata   <= 16'h0000;
    end else begin
      rsp_rdata <= sd_read_data;
      rsp_valid <= '0;
      if (burst_beat && !sd_rw && beat_idx >= SKIP_BEATS) rsp_valid <= grant_oh;

      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            state <= ST_ARB;
            busy  <= 1'b1;
          end
        end
        ST_ARB: begin
          if (arb_any) begin
            grant_q    <= arb_grant;
            ptr        <= arb_grant;
            sd_rw      <= rw_sel;
            sd_address <= addr_sel;
            to_cnt     <= 16'd0;
            beat_cnt   <= 8'd0;
            sd_ce      <= 1'b1;
            sd_rw_req  <= 1'b1;
            state      <= ST_REQ;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_REQ: begin
          if (sd_data_bursting) begin
            sd_rw_req <= 1'b0;
            beat_cnt  <= 8'd1;
            state     <= ST_BURST;
          end else if (to_cnt == (TIMEOUT - 16'd1)) begin
            timeout_err <= 1'b1;
            sd_ce       <= 1'b0;
            sd_rw_req   <= 1'b0;
            state       <= ST_DONE;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        ST_BURST: begin
          if (sd_data_bursting) begin
            if (beat_cnt != 8'hFF) beat_cnt <= beat_cnt + 8'd1;
          end else begin
            sd_ce <= 1'b0;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          sd_ce <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter NUM_REQ, 3, number of requester ports; fixed at 3 for this revision.
REQ-002 Parameter BURST_LEN, 8'd32, burst length driven on sd_burst_len for every transaction.
REQ-003 Parameter READ_SKIP, 2, leading sd_data_bursting cycles of a read that carry no data.
REQ-004 Parameter TIMEOUT, 16'd4095, maximum cycles REQ may wait for sd_data_bursting to rise.
REQ-005 clk  in  1  system clock; all logic on the rising edge.
REQ-006 reset  in  1  one clock; reset is asynchronous and active-low.
REQ-007 req_valid  in  3  per-requester transaction request, held until req_ready.
REQ-008 req_rw  in  3  per-requester direction: 1 = write, 0 = read.
REQ-009 req_addr  in  96  three 32-bit byte addresses; requester i uses bits [32i+31:32i].
REQ-010 req_wdata  in  48  three 16-bit write words; requester i uses bits [16i+15:16i].
REQ-011 req_ready  out  3  one-cycle acceptance pulse to the granted requester.
REQ-012 wr_take  out  3  write beat consumed; requester presents the next word on the following cycle.
REQ-013 rsp_valid  out  3  read beat valid on rsp_rdata for the indicated requester.
REQ-014 rsp_rdata  out  16  read data, registered copy of sd_read_data.
REQ-015 busy  out  1  high whenever state is not IDLE.
REQ-016 timeout_err  out  1  sticky; set on accept timeout, cleared only by reset.
REQ-017 sd_ce, sd_rw_req, sd_rw  out  1 each  request strobe set toward the burst controller.
REQ-018 sd_address  out  32, sd_burst_len  out  8, sd_write_data  out  16  controller request fields.
REQ-019 sd_read_data  in  16, sd_data_bursting  in  1  controller read data and burst-active flag.

Function
REQ-020 The FSM SHALL have states IDLE, ARB, REQ, BURST, DONE.
REQ-021 IDLE -> ARB when any req_valid is high; otherwise stay.
REQ-022 ARB SHALL grant round-robin, starting the search at ptr+1 mod 3, and latch grant index, rw and address, all in one cycle -> REQ.
REQ-023 ARB SHALL pulse req_ready[grant] for exactly that cycle; ptr <= grant.
REQ-024 REQ SHALL hold sd_ce=sd_rw_req=1 with latched sd_address/sd_rw; -> BURST on the first cycle sd_data_bursting=1.
REQ-025 REQ SHALL count cycles; on reaching TIMEOUT, set timeout_err, drop the strobe and go -> DONE.
REQ-026 BURST SHALL deassert sd_rw_req and count beats while sd_data_bursting=1; -> DONE on its first low cycle.
REQ-027 Write in BURST: sd_write_data = req_wdata[grant] combinationally; wr_take[grant] high each bursting cycle.
REQ-028 Read in BURST: rsp_rdata registered from sd_read_data; rsp_valid[grant] asserted one cycle after each bursting cycle whose beat count >= READ_SKIP.
REQ-029 DONE SHALL last exactly one cycle, then -> IDLE; ptr is retained.
REQ-030 The beat counter SHALL be 8 bits and saturate at 255; the timeout counter SHALL be 16 bits and clear on entry to REQ.
REQ-031 req_valid changes outside ARB SHALL be ignored; a request dropped before its grant is never served.
REQ-032 Simultaneous requests SHALL be served in strict rotation, one transaction each, with no starvation beyond 2 intervening transactions.
REQ-033 sd_burst_len SHALL be constant BURST_LEN.

Reset
REQ-034 Asynchronous reset low SHALL force: state IDLE, ptr=2 (requester 0 first), and every output 0 (including sd_ce, sd_rw_req, req_ready, wr_take, rsp_valid, busy, timeout_err); counters 0.
REQ-035 Reset asserted mid-BURST SHALL abandon the transaction with no further strobes; deassertion SHALL be synchronised by a 2-flop release.

Structure
REQ-036 State encoding, NUM_REQ and the default parameter values SHALL live in a shared sdram package.
REQ-037 The round-robin selector SHALL be a sub-module rr_arbiter3 (req[2:0], ptr[1:0] -> grant[1:0], any).

Verification
REQ-038 Single read from requester 1, addr 0x00012000 -> sd_address=0x00012000, sd_rw=0; rsp_valid[1] count = bursting cycles - 2.
REQ-039 All three request in the same cycle after reset -> grants in order 0,1,2; req_ready single-cycle each.
REQ-040 Write from requester 2 with 32 bursting cycles -> wr_take[2] high for exactly 32 cycles; sd_write_data tracks req_wdata[2].
REQ-041 sd_data_bursting held low in REQ -> timeout_err set at cycle 4095, FSM -> DONE -> IDLE, next request still served.
REQ-042 Reset pulled low during BURST -> all outputs 0 asynchronously; first grant after release goes to requester 0.
REQ-043 Requester 0 continuously requesting while 1 waits -> requester 1 granted on the next arbitration.
